uart_fifo_core: RTL and testbench
=================================

Name: uart_fifo_core

Overview:
- Parametrised successor to the fixed 8N1 UART used by the SoC board tops.
- Full-duplex UART with configurable data width, parity and stop bits, and a TX FIFO and an RX FIFO, each exposed through a valid/ready stream handshake.
- Sits between the SoC bus bridge and the board `uart_rx`/`uart_tx` pins.
- Adds behaviour the current UART lacks: buffering, parity and frame checking, and overrun detection.

Parameters:
- CLOCK_FREQUENCY, 27000000: system clock in Hz.
- UART_BAUD_RATE, 9600: line rate in baud. CYCLES_PER_BIT = CLOCK_FREQUENCY / UART_BAUD_RATE, integer truncation; must be >= 4.
- DATA_BITS, 8: payload bits per frame, legal range 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: entries per FIFO; power of two, >= 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_BITS  byte to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  DATA_BITS  head of RX FIFO.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  consumer pops the RX FIFO head.
- rx_parity_error  out  1  sticky parity error.
- rx_frame_error  out  1  sticky stop-bit error.
- rx_overrun  out  1  sticky: frame dropped because RX FIFO was full.
- error_clear  in  1  clears all three sticky flags.
- tx_count  out  clog2(FIFO_DEPTH)+1  TX FIFO occupancy.
- rx_count  out  clog2(FIFO_DEPTH)+1  RX FIFO occupancy.
- uart_rx  in  1  serial input, asynchronous to clock.
- uart_tx  out  1  serial output, idle high.

Behaviour:
- Reset (reset=0, asynchronous):
  - uart_tx=1, tx_ready=1, rx_valid=0, rx_data=0.
  - All error flags 0, both counts 0, both FSMs IDLE.
  - RX synchroniser flops preset to 1.
  - Reset asserted mid-frame aborts the frame immediately; uart_tx returns to 1 in the same asynchronous event.
- FIFOs:
  - Push on valid&ready; pop on valid&ready.
  - Simultaneous push and pop while not empty and not full: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - rx_data is registered FIFO head output, valid whenever rx_valid=1.
  - A push becomes visible on the pop side on the next cycle (1-cycle latency).
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - Leaves IDLE the cycle after TX FIFO becomes non-empty; pops one entry on entry to START.
  - Each state holds uart_tx for exactly CYCLES_PER_BIT cycles.
  - DATA is sent LSB first for DATA_BITS bits.
  - PARITY state is skipped when PARITY=0. Parity bit = XOR of data bits for even; inverted for odd.
  - STOP drives 1 for STOP_BITS × CYCLES_PER_BIT cycles, then returns to IDLE.
  - Back-to-back frames have no extra idle cycles when the FIFO is non-empty.
- RX path:
  - uart_rx passes through a 2-flop synchroniser.
  - FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START on a synchronised falling edge.
  - START checks the line at CYCLES_PER_BIT/2. If the line is 1 (glitch), return to IDLE with no flag set.
  - All further bits are sampled at CYCLES_PER_BIT intervals from the mid-start point, LSB first.
  - Only the first stop bit is checked. Stop sample = 0 sets rx_frame_error and the frame is discarded.
  - Parity mismatch sets rx_parity_error; the frame is still pushed.
  - Push happens at the stop-bit sample.
  - If the RX FIFO is full at push time, the frame is dropped, rx_overrun is set, and FIFO contents are unchanged.
  - After the stop sample, the FSM returns to IDLE and can accept a new start bit immediately.
- Error flags:
  - Sticky until error_clear=1.
  - If a set event and error_clear occur in the same cycle, set wins.

Test Plan:
- CLOCK_FREQUENCY=1000000, UART_BAUD_RATE=100000 (10 cycles/bit), 8N1; push 0xA5 -> uart_tx low 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles; tx_count 1→0 at START.
- Same bench, PARITY=2, STOP_BITS=2; push 0x07 -> parity bit 1, stop high 20 cycles; loopback uart_tx→uart_rx gives rx_data=0x07, rx_valid=1, no error flags.
- FIFO_DEPTH=4, rx_ready=0; drive 5 frames 0x11..0x55 -> rx_count=4, rx_overrun=1, pops return 0x11,0x22,0x33,0x44; error_clear -> rx_overrun=0.
- Drive frame 0x3C with stop bit 0 -> rx_frame_error=1, rx_count unchanged. Drive 0x3C with wrong parity (PARITY=1) -> rx_parity_error=1, rx_data=0x3C pushed.
- 3-cycle low glitch on uart_rx -> no frame received, no flags, RX FSM back in IDLE.
- Assert reset mid-DATA of a TX frame -> uart_tx=1 and tx_count=0 immediately; after release a new push transmits correctly.

Source files
------------

// File: rtl/uart_fifo_core_if.sv
// Byte-stream handshake bundle between the bus bridge (master) and the UART core (slave).
// TX stream flows into the core and RX stream flows out; both use valid/ready.
interface uart_fifo_core_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid,
    input  rx_ready
  );
endinterface

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with configurable framing, TX/RX FIFOs and sticky parity/frame/overrun flags.
// FIFO heads, status bits and the serial line are all driven straight from flops.
module uart_fifo_core #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int UART_BAUD_RATE  = 9600,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  uart_fifo_core_if.slave               bus,
  output logic                          rx_parity_error,
  output logic                          rx_frame_error,
  output logic                          rx_overrun,
  input  logic                          error_clear,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  input  logic                          uart_rx,
  output logic                          uart_tx
);

  localparam int CPB = CLOCK_FREQUENCY / UART_BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = $clog2(STOP_BITS * CPB) + 1;

  localparam logic [BCW-1:0] BIT_LAST   = BCW'(CPB - 1);
  localparam logic [BCW-1:0] STOP_LAST  = BCW'(STOP_BITS * CPB - 1);
  localparam logic [BCW-1:0] HALF_LAST  = BCW'(CPB / 2 - 1);
  localparam logic [BCW-1:0] BAUD_ZERO  = BCW'(0);
  localparam logic [BCW-1:0] BAUD_ONE   = BCW'(1);
  localparam logic [CW-1:0]  FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  ZERO_COUNT = CW'(0);
  localparam logic [AW-1:0]  PTR_ONE    = AW'(1);
  localparam logic [2:0]     LAST_BIT   = 3'(DATA_BITS - 1);
  localparam logic [DATA_BITS-1:0] WORD_ZERO = {DATA_BITS{1'b0}};

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Even parity is the XOR of the payload; odd parity inverts it.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY == 1);
  endfunction

  logic [DATA_BITS-1:0] tx_mem_r [FIFO_DEPTH];
  logic [AW-1:0]        tx_wr_r, tx_rd_r, tx_rd_nx_s;
  logic [CW-1:0]        tx_count_r, tx_count_nx_s;
  logic                 tx_space_r, tx_avail_r, tx_push_s, tx_pop_s;
  logic [DATA_BITS-1:0] tx_head_r;

  logic [DATA_BITS-1:0] rx_mem_r [FIFO_DEPTH];
  logic [AW-1:0]        rx_wr_r, rx_rd_r, rx_rd_nx_s;
  logic [CW-1:0]        rx_count_r, rx_count_nx_s;
  logic                 rx_space_r, rx_avail_r, rx_push_s, rx_pop_s;
  logic [DATA_BITS-1:0] rx_head_r;

  tx_state_t            tx_state_r;
  logic                 tx_line_r, tx_par_r;
  logic [BCW-1:0]       tx_baud_r;
  logic [2:0]           tx_bit_r;
  logic [DATA_BITS-1:0] tx_shift_r;

  rx_state_t            rx_state_r;
  logic                 rx_sync1_r, rx_sync2_r, rx_prev_r;
  logic [BCW-1:0]       rx_baud_r;
  logic [2:0]           rx_bit_r;
  logic [DATA_BITS-1:0] rx_shift_r, rx_word_r;
  logic                 rx_push_r, rx_perr_set_r, rx_ferr_set_r;
  logic                 rx_perr_r, rx_ferr_r, rx_ovr_r, rx_ovr_set_s;

  // The sequencer takes the next entry when idle, or at the end of a stop bit so frames abut.
  always_comb begin
    tx_pop_s = 1'b0;
    if (tx_avail_r && ((tx_state_r == TX_IDLE) ||
        ((tx_state_r == TX_STOP) && (tx_baud_r == BAUD_ZERO)))) begin
      tx_pop_s = 1'b1;
    end else begin
      tx_pop_s = 1'b0;
    end
  end

  // Next-state arithmetic for both FIFOs.
  always_comb begin
    tx_push_s     = bus.tx_valid & tx_space_r;
    tx_rd_nx_s    = tx_rd_r + AW'(tx_pop_s);
    tx_count_nx_s = tx_count_r + CW'(tx_push_s) - CW'(tx_pop_s);
    rx_push_s     = rx_push_r & rx_space_r;
    rx_pop_s      = rx_avail_r & bus.rx_ready;
    rx_rd_nx_s    = rx_rd_r + AW'(rx_pop_s);
    rx_count_nx_s = rx_count_r + CW'(rx_push_s) - CW'(rx_pop_s);
    rx_ovr_set_s  = rx_push_r & ~rx_space_r;
  end

  // TX FIFO storage, pointers and registered head; a word written into an empty slot bypasses to the head.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) tx_mem_r[i] <= WORD_ZERO;
      tx_wr_r    <= AW'(0);
      tx_rd_r    <= AW'(0);
      tx_count_r <= ZERO_COUNT;
      tx_space_r <= 1'b1;
      tx_avail_r <= 1'b0;
      tx_head_r  <= WORD_ZERO;
    end else begin
      if (tx_push_s) begin
        tx_mem_r[tx_wr_r] <= bus.tx_data;
        tx_wr_r           <= tx_wr_r + PTR_ONE;
      end
      tx_rd_r    <= tx_rd_nx_s;
      tx_count_r <= tx_count_nx_s;
      tx_space_r <= (tx_count_nx_s != FULL_COUNT);
      tx_avail_r <= (tx_count_nx_s != ZERO_COUNT);
      tx_head_r  <= (tx_push_s && (tx_wr_r == tx_rd_nx_s)) ? bus.tx_data : tx_mem_r[tx_rd_nx_s];
    end
  end

  // RX FIFO storage, pointers and registered head; pushes arriving while full are dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) rx_mem_r[i] <= WORD_ZERO;
      rx_wr_r    <= AW'(0);
      rx_rd_r    <= AW'(0);
      rx_count_r <= ZERO_COUNT;
      rx_space_r <= 1'b1;
      rx_avail_r <= 1'b0;
      rx_head_r  <= WORD_ZERO;
    end else begin
      if (rx_push_s) begin
        rx_mem_r[rx_wr_r] <= rx_word_r;
        rx_wr_r           <= rx_wr_r + PTR_ONE;
      end
      rx_rd_r    <= rx_rd_nx_s;
      rx_count_r <= rx_count_nx_s;
      rx_space_r <= (rx_count_nx_s != FULL_COUNT);
      rx_avail_r <= (rx_count_nx_s != ZERO_COUNT);
      rx_head_r  <= (rx_push_s && (rx_wr_r == rx_rd_nx_s)) ? rx_word_r : rx_mem_r[rx_rd_nx_s];
    end
  end

  // Transmit sequencer: every state holds the line for one bit time, stop holds STOP_BITS of them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_r <= TX_IDLE;
      tx_line_r  <= 1'b1;
      tx_baud_r  <= BAUD_ZERO;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= WORD_ZERO;
      tx_par_r   <= 1'b0;
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          if (tx_pop_s) begin
            tx_state_r <= TX_START;
            tx_line_r  <= 1'b0;
            tx_baud_r  <= BIT_LAST;
            tx_shift_r <= tx_head_r;
            tx_par_r   <= parity_of(tx_head_r);
          end else begin
            tx_line_r  <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_baud_r == BAUD_ZERO) begin
            tx_state_r <= TX_DATA;
            tx_line_r  <= tx_shift_r[0];
            tx_shift_r <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
            tx_baud_r  <= BIT_LAST;
            tx_bit_r   <= 3'd0;
          end else begin
            tx_baud_r  <= tx_baud_r - BAUD_ONE;
          end
        end
        TX_DATA: begin
          if (tx_baud_r == BAUD_ZERO) begin
            tx_baud_r <= BIT_LAST;
            if (tx_bit_r != LAST_BIT) begin
              tx_line_r  <= tx_shift_r[0];
              tx_shift_r <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
              tx_bit_r   <= tx_bit_r + 3'd1;
            end else if (PARITY != 0) begin
              tx_state_r <= TX_PARITY;
              tx_line_r  <= tx_par_r;
            end else begin
              tx_state_r <= TX_STOP;
              tx_line_r  <= 1'b1;
              tx_baud_r  <= STOP_LAST;
            end
          end else begin
            tx_baud_r <= tx_baud_r - BAUD_ONE;
          end
        end
        TX_PARITY: begin
          if (tx_baud_r == BAUD_ZERO) begin
            tx_state_r <= TX_STOP;
            tx_line_r  <= 1'b1;
            tx_baud_r  <= STOP_LAST;
          end else begin
            tx_baud_r  <= tx_baud_r - BAUD_ONE;
          end
        end
        TX_STOP: begin
          if (tx_baud_r != BAUD_ZERO) begin
            tx_baud_r  <= tx_baud_r - BAUD_ONE;
          end else if (tx_pop_s) begin
            tx_state_r <= TX_START;
            tx_line_r  <= 1'b0;
            tx_baud_r  <= BIT_LAST;
            tx_shift_r <= tx_head_r;
            tx_par_r   <= parity_of(tx_head_r);
          end else begin
            tx_state_r <= TX_IDLE;
            tx_line_r  <= 1'b1;
          end
        end
        default: begin
          tx_state_r <= TX_IDLE;
          tx_line_r  <= 1'b1;
        end
      endcase
    end
  end

  // Two-flop synchroniser plus one delayed copy for falling-edge detection; idles high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_sync1_r <= 1'b1;
      rx_sync2_r <= 1'b1;
      rx_prev_r  <= 1'b1;
    end else begin
      rx_sync1_r <= uart_rx;
      rx_sync2_r <= rx_sync1_r;
      rx_prev_r  <= rx_sync2_r;
    end
  end

  // Receive sequencer: samples mid-bit, pushes at the first stop sample, discards on a bad stop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state_r    <= RX_IDLE;
      rx_baud_r     <= BAUD_ZERO;
      rx_bit_r      <= 3'd0;
      rx_shift_r    <= WORD_ZERO;
      rx_word_r     <= WORD_ZERO;
      rx_push_r     <= 1'b0;
      rx_perr_set_r <= 1'b0;
      rx_ferr_set_r <= 1'b0;
    end else begin
      rx_push_r     <= 1'b0;
      rx_perr_set_r <= 1'b0;
      rx_ferr_set_r <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          if (rx_prev_r && !rx_sync2_r) begin
            rx_state_r <= RX_START;
            rx_baud_r  <= HALF_LAST;
          end
        end
        RX_START: begin
          if (rx_baud_r != BAUD_ZERO) begin
            rx_baud_r  <= rx_baud_r - BAUD_ONE;
          end else if (rx_sync2_r) begin
            rx_state_r <= RX_IDLE;
          end else begin
            rx_state_r <= RX_DATA;
            rx_baud_r  <= BIT_LAST;
            rx_bit_r   <= 3'd0;
          end
        end
        RX_DATA: begin
          if (rx_baud_r == BAUD_ZERO) begin
            rx_shift_r <= {rx_sync2_r, rx_shift_r[DATA_BITS-1:1]};
            rx_baud_r  <= BIT_LAST;
            if (rx_bit_r != LAST_BIT) begin
              rx_bit_r   <= rx_bit_r + 3'd1;
            end else if (PARITY != 0) begin
              rx_state_r <= RX_PARITY;
            end else begin
              rx_state_r <= RX_STOP;
            end
          end else begin
            rx_baud_r <= rx_baud_r - BAUD_ONE;
          end
        end
        RX_PARITY: begin
          if (rx_baud_r == BAUD_ZERO) begin
            rx_perr_set_r <= (rx_sync2_r != parity_of(rx_shift_r));
            rx_state_r    <= RX_STOP;
            rx_baud_r     <= BIT_LAST;
          end else begin
            rx_baud_r     <= rx_baud_r - BAUD_ONE;
          end
        end
        RX_STOP: begin
          if (rx_baud_r == BAUD_ZERO) begin
            rx_state_r <= RX_IDLE;
            if (rx_sync2_r) begin
              rx_push_r <= 1'b1;
              rx_word_r <= rx_shift_r;
            end else begin
              rx_ferr_set_r <= 1'b1;
            end
          end else begin
            rx_baud_r <= rx_baud_r - BAUD_ONE;
          end
        end
        default: begin
          rx_state_r <= RX_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a set event in the same cycle as error_clear keeps the flag set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_perr_r <= 1'b0;
      rx_ferr_r <= 1'b0;
      rx_ovr_r  <= 1'b0;
    end else begin
      rx_perr_r <= rx_perr_set_r | (rx_perr_r & ~error_clear);
      rx_ferr_r <= rx_ferr_set_r | (rx_ferr_r & ~error_clear);
      rx_ovr_r  <= rx_ovr_set_s  | (rx_ovr_r  & ~error_clear);
    end
  end

  assign bus.tx_ready    = tx_space_r;
  assign bus.rx_valid    = rx_avail_r;
  assign bus.rx_data     = rx_head_r;
  assign tx_count        = tx_count_r;
  assign rx_count        = rx_count_r;
  assign rx_parity_error = rx_perr_r;
  assign rx_frame_error  = rx_ferr_r;
  assign rx_overrun      = rx_ovr_r;
  assign uart_tx         = tx_line_r;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: 8N1 core (a), 8E2 loopback core (b), 8O1 core (c), 10 clocks per bit.
module tb_uart_fifo_core;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  uart_fifo_core_if #(.DATA_BITS(8)) bus_a ();
  uart_fifo_core_if #(.DATA_BITS(8)) bus_b ();
  uart_fifo_core_if #(.DATA_BITS(8)) bus_c ();

  logic       perr_a, ferr_a, ovr_a, clr_a, line_a, tx_a;
  logic       perr_b, ferr_b, ovr_b, clr_b, tx_b;
  logic       perr_c, ferr_c, ovr_c, clr_c, line_c, tx_c;
  logic [2:0] txc_a, rxc_a, txc_c, rxc_c;
  logic [4:0] txc_b, rxc_b;

  uart_fifo_core #(.CLOCK_FREQUENCY(1000000), .UART_BAUD_RATE(100000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a),
    .rx_parity_error(perr_a), .rx_frame_error(ferr_a), .rx_overrun(ovr_a),
    .error_clear(clr_a), .tx_count(txc_a), .rx_count(rxc_a),
    .uart_rx(line_a), .uart_tx(tx_a));

  uart_fifo_core #(.CLOCK_FREQUENCY(1000000), .UART_BAUD_RATE(100000), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b),
    .rx_parity_error(perr_b), .rx_frame_error(ferr_b), .rx_overrun(ovr_b),
    .error_clear(clr_b), .tx_count(txc_b), .rx_count(rxc_b),
    .uart_rx(tx_b), .uart_tx(tx_b));

  uart_fifo_core #(.CLOCK_FREQUENCY(1000000), .UART_BAUD_RATE(100000), .DATA_BITS(8),
                   .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
    .clock(clock), .reset(reset), .bus(bus_c),
    .rx_parity_error(perr_c), .rx_frame_error(ferr_c), .rx_overrun(ovr_c),
    .error_clear(clr_c), .tx_count(txc_c), .rx_count(rxc_c),
    .uart_rx(line_c), .uart_tx(tx_c));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_line(input bit to_c, input logic v);
    if (to_c) line_c = v;
    else      line_a = v;
  endtask

  // Serial frame into core a or c: start, 8 data LSB first, optional parity, one stop, then idle.
  task automatic drive_frame(input bit to_c, input logic [7:0] d, input bit with_par,
                             input logic par, input logic stop);
    set_line(to_c, 1'b0);
    repeat (10) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      set_line(to_c, d[i]);
      repeat (10) @(negedge clock);
    end
    if (with_par) begin
      set_line(to_c, par);
      repeat (10) @(negedge clock);
    end
    set_line(to_c, stop);
    repeat (10) @(negedge clock);
    set_line(to_c, 1'b1);
    repeat (20) @(negedge clock);
  endtask

  // Waits (bounded) for the start bit, then compares every cycle against bits[t/10], bit 0 = start.
  task automatic check_wave(input string tag, input bit on_b, input logic [15:0] bits, input int nbits);
    int   waited = 0;
    int   mism = 0;
    logic ln;
    ln = on_b ? tx_b : tx_a;
    while (ln !== 1'b0 && waited < 50) begin
      @(negedge clock);
      waited++;
      ln = on_b ? tx_b : tx_a;
    end
    check_eq({tag, "_start_seen"}, {31'd0, ln === 1'b0}, 32'd1);
    for (int t = 0; t < nbits * 10; t++) begin
      ln = on_b ? tx_b : tx_a;
      if (ln !== bits[t / 10]) mism++;
      @(negedge clock);
    end
    check_eq({tag, "_wave_errs"}, mism, 32'd0);
  endtask

  logic [7:0] exp_pop [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    int w;
    reset = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    line_a = 1'b1; line_c = 1'b1;
    bus_a.tx_data = 8'h00; bus_a.tx_valid = 1'b0; bus_a.rx_ready = 1'b0;
    bus_b.tx_data = 8'h00; bus_b.tx_valid = 1'b0; bus_b.rx_ready = 1'b0;
    bus_c.tx_data = 8'h00; bus_c.tx_valid = 1'b0; bus_c.rx_ready = 1'b0;
    repeat (3) @(negedge clock);

    check_eq("rst_uart_tx", tx_a, 1);
    check_eq("rst_tx_ready", bus_a.tx_ready, 1);
    check_eq("rst_rx_valid", bus_a.rx_valid, 0);
    check_eq("rst_rx_data", bus_a.rx_data, 8'h00);
    check_eq("rst_flags", {perr_a, ferr_a, ovr_a}, 3'b000);
    check_eq("rst_counts", {txc_a, rxc_a}, 6'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // 8N1 0xA5: {stop=1, A5, start=0} = 10'b11_0100_1010
    bus_a.tx_data = 8'hA5; bus_a.tx_valid = 1'b1;
    @(negedge clock);
    bus_a.tx_valid = 1'b0;
    check_eq("a5_count_pushed", txc_a, 1);
    @(negedge clock);
    check_eq("a5_count_start", txc_a, 0);
    check_eq("a5_line_start", tx_a, 0);
    check_wave("a5", 1'b0, 16'h034A, 10);
    check_eq("a5_idle_after", tx_a, 1);

    // 8E2 0x07: {stop,stop,par=1, 07, start} = 12'b1110_0000_1110, looped back into RX
    bus_b.tx_data = 8'h07; bus_b.tx_valid = 1'b1;
    @(negedge clock);
    bus_b.tx_valid = 1'b0;
    @(negedge clock);
    check_wave("p07", 1'b1, 16'h0E0E, 12);
    w = 0;
    while (!bus_b.rx_valid && w < 100) begin @(negedge clock); w++; end
    check_eq("p07_rx_valid", bus_b.rx_valid, 1);
    check_eq("p07_rx_data", bus_b.rx_data, 8'h07);
    check_eq("p07_flags", {perr_b, ferr_b, ovr_b}, 3'b000);
    check_eq("p07_rx_count", rxc_b, 1);
    bus_b.rx_ready = 1'b1;
    @(negedge clock);
    bus_b.rx_ready = 1'b0;
    check_eq("p07_popped_count", rxc_b, 0);

    // Overrun: five frames into a 4-deep RX FIFO with no consumer
    for (int i = 1; i <= 5; i++) drive_frame(1'b0, 8'(i * 17), 1'b0, 1'b0, 1'b1);
    check_eq("ovr_rx_count", rxc_a, 4);
    check_eq("ovr_flag", ovr_a, 1);
    check_eq("ovr_other_flags", {perr_a, ferr_a}, 2'b00);
    for (int i = 0; i < 4; i++) begin
      check_eq("ovr_pop_valid", bus_a.rx_valid, 1);
      check_eq("ovr_pop_data", bus_a.rx_data, exp_pop[i]);
      bus_a.rx_ready = 1'b1;
      @(negedge clock);
      bus_a.rx_ready = 1'b0;
    end
    check_eq("ovr_drained_count", rxc_a, 0);
    check_eq("ovr_drained_valid", bus_a.rx_valid, 0);
    clr_a = 1'b1;
    @(negedge clock);
    clr_a = 1'b0;
    check_eq("ovr_cleared", ovr_a, 0);

    // Bad stop bit: flagged and discarded
    drive_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    check_eq("ferr_flag", ferr_a, 1);
    check_eq("ferr_rx_count", rxc_a, 0);

    // Odd parity on core c: 0x3C has four ones, so correct parity bit is 1
    drive_frame(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
    check_eq("par_good_flag", perr_c, 0);
    check_eq("par_good_count", rxc_c, 1);
    drive_frame(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
    check_eq("par_bad_flag", perr_c, 1);
    check_eq("par_bad_count", rxc_c, 2);
    check_eq("par_bad_data", bus_c.rx_data, 8'h3C);
    check_eq("par_bad_ferr", ferr_c, 0);

    // Short low glitch must be rejected without flags, and the receiver must stay usable
    clr_a = 1'b1;
    @(negedge clock);
    clr_a = 1'b0;
    check_eq("glitch_pre_clear", ferr_a, 0);
    line_a = 1'b0;
    repeat (3) @(negedge clock);
    line_a = 1'b1;
    repeat (30) @(negedge clock);
    check_eq("glitch_rx_count", rxc_a, 0);
    check_eq("glitch_flags", {perr_a, ferr_a, ovr_a}, 3'b000);
    drive_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    check_eq("glitch_next_count", rxc_a, 1);
    check_eq("glitch_next_data", bus_a.rx_data, 8'h5A);

    // Reset in the middle of a TX data phase
    bus_a.tx_data = 8'h00; bus_a.tx_valid = 1'b1;
    @(negedge clock);
    bus_a.tx_data = 8'h81;
    @(negedge clock);
    bus_a.tx_valid = 1'b0;
    w = 0;
    while (tx_a !== 1'b0 && w < 50) begin @(negedge clock); w++; end
    repeat (25) @(negedge clock);
    check_eq("mid_data_line", tx_a, 0);
    check_eq("mid_data_count", txc_a, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("async_rst_line", tx_a, 1);
    check_eq("async_rst_count", txc_a, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    bus_a.tx_data = 8'hA5; bus_a.tx_valid = 1'b1;
    @(negedge clock);
    bus_a.tx_valid = 1'b0;
    check_wave("a5_after_rst", 1'b0, 16'h034A, 10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
